// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for mem_arbiter: owner encoding, arbiter FSM states and default sizing.
package mem_arbiter_pkg;

  localparam int unsigned DEFAULT_ADDR_WIDTH = 15;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_IC   = 2'b01;
  localparam logic [1:0] OWN_DC   = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StGntIc,
    StGntDc
  } arb_state_e;

endpackage

// File: rtl/arb_req_latch.sv
// One-deep beat holding register for a requester that is not currently granted.
// Pop and push in the same cycle replace the held beat with the new one.
module arb_req_latch #(
  parameter int unsigned Width = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [Width-1:0] i_data,
  output logic             o_valid,
  output logic [Width-1:0] o_data
);

  logic             valid_q, valid_d;
  logic [Width-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (i_pop) begin
      valid_d = 1'b0;
    end
    // A push into a full, non-draining holder is dropped; requesters must not overrun it.
    if (i_push && (!valid_q || i_pop)) begin
      valid_d = 1'b1;
      data_d  = i_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-refill (IC) and data (DC) beats onto one in-order memory port.
// Define ARB_ROUND_ROBIN_EN to break IDLE ties round-robin instead of fixed DC priority.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = DEFAULT_ADDR_WIDTH,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [ADDR_WIDTH-1:0] i_ic_addr,
  input  logic                  i_ic_stb,
  output logic                  o_ic_ack,
  output logic [31:0]           o_ic_data,
  input  logic [ADDR_WIDTH-1:0] i_dc_addr,
  input  logic                  i_dc_stb,
  input  logic                  i_dc_we,
  input  logic [31:0]           i_dc_wdata,
  input  logic [3:0]            i_dc_wsel,
  output logic                  o_dc_ack,
  output logic [31:0]           o_dc_data,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_stb,
  output logic                  o_mem_we,
  output logic [31:0]           o_mem_wdata,
  output logic [3:0]            o_mem_wsel,
  input  logic                  i_mem_ack,
  input  logic [31:0]           i_mem_data,
  output logic [1:0]            o_owner,
  output logic                  o_err
);

  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_OUTSTANDING);
  localparam int unsigned DcW = ADDR_WIDTH + 1 + 32 + 4;

  arb_state_e            state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  mem_stb_q, mem_stb_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic [3:0]            mem_wsel_q, mem_wsel_d;

  logic                  ic_req, dc_req, ic_sel, dc_sel, pick_dc;
  logic                  ic_push, ic_pop, ic_valid;
  logic                  dc_push, dc_pop, dc_valid;
  logic [ADDR_WIDTH-1:0] ic_lat_addr;
  logic [DcW-1:0]        dc_live, dc_lat_data;

  assign dc_live = {i_dc_addr, i_dc_we, i_dc_wdata, i_dc_wsel};
  assign ic_req  = i_ic_stb | ic_valid;
  assign dc_req  = i_dc_stb | dc_valid;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_dc_q, last_dc_d;

  assign pick_dc   = ~last_dc_q;
  assign last_dc_d = (state_q == StIdle && (ic_sel || dc_sel)) ? dc_sel : last_dc_q;

  // DC counts as served last out of reset so the first tie goes to IC.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_dc_q <= 1'b1;
    end else begin
      last_dc_q <= last_dc_d;
    end
  end
`else
  assign pick_dc = 1'b1;
`endif

  // Grant FSM; ic_sel/dc_sel name the requester whose beat is forwarded this cycle.
  always_comb begin
    state_d = state_q;
    ic_sel  = 1'b0;
    dc_sel  = 1'b0;
    case (state_q)
      StIdle: begin
        if (ic_req && dc_req) begin
          dc_sel = pick_dc;
          ic_sel = ~pick_dc;
        end else begin
          dc_sel = dc_req;
          ic_sel = ic_req;
        end
        if (dc_sel) begin
          state_d = StGntDc;
        end else if (ic_sel) begin
          state_d = StGntIc;
        end
      end
      StGntIc: begin
        ic_sel = ic_req;
        if (!ic_req && !mem_stb_q && cnt_q == '0 && !i_mem_ack) begin
          state_d = StIdle;
        end
      end
      StGntDc: begin
        dc_sel = dc_req;
        if (!dc_req && !mem_stb_q && cnt_q == '0 && !i_mem_ack) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A held beat is older than a live one, so it goes first and the live beat takes its slot.
  assign ic_pop  = ic_sel & ic_valid;
  assign dc_pop  = dc_sel & dc_valid;
  assign ic_push = i_ic_stb & ~(ic_sel & ~ic_valid);
  assign dc_push = i_dc_stb & ~(dc_sel & ~dc_valid);

  always_comb begin
    mem_stb_d   = 1'b0;
    mem_addr_d  = '0;
    mem_we_d    = 1'b0;
    mem_wdata_d = '0;
    mem_wsel_d  = '0;
    if (dc_sel) begin
      mem_stb_d = 1'b1;
      {mem_addr_d, mem_we_d, mem_wdata_d, mem_wsel_d} = dc_valid ? dc_lat_data : dc_live;
    end else if (ic_sel) begin
      mem_stb_d  = 1'b1;
      mem_addr_d = ic_valid ? ic_lat_addr : i_ic_addr;
    end
  end

  // Outstanding beats: saturate at both ends and flag the protocol error instead.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    case ({mem_stb_q, i_mem_ack})
      2'b10: begin
        if (cnt_q == MaxCnt) begin
          err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      2'b01: begin
        if (cnt_q == '0) begin
          err_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      mem_stb_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wsel_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      mem_stb_q   <= mem_stb_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wsel_q  <= mem_wsel_d;
    end
  end

  arb_req_latch #(
    .Width(ADDR_WIDTH)
  ) u_ic_latch (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_push (ic_push),
    .i_pop  (ic_pop),
    .i_data (i_ic_addr),
    .o_valid(ic_valid),
    .o_data (ic_lat_addr)
  );

  arb_req_latch #(
    .Width(DcW)
  ) u_dc_latch (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_push (dc_push),
    .i_pop  (dc_pop),
    .i_data (dc_live),
    .o_valid(dc_valid),
    .o_data (dc_lat_data)
  );

  always_comb begin
    case (state_q)
      StGntIc: o_owner = OWN_IC;
      StGntDc: o_owner = OWN_DC;
      default: o_owner = OWN_NONE;
    endcase
  end

  assign o_ic_ack    = i_mem_ack & (state_q == StGntIc);
  assign o_dc_ack    = i_mem_ack & (state_q == StGntDc);
  assign o_ic_data   = (state_q == StGntIc) ? i_mem_data : '0;
  assign o_dc_data   = (state_q == StGntDc) ? i_mem_data : '0;
  assign o_mem_stb   = mem_stb_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_mem_wsel  = mem_wsel_q;
  assign o_err       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized checks of mem_arbiter against a beat-level scoreboard.
// Honours ARB_ROUND_ROBIN_EN when compiled with it.
module tb_mem_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [14:0] i_ic_addr = '0;
  logic        i_ic_stb = 1'b0;
  logic        o_ic_ack;
  logic [31:0] o_ic_data;
  logic [14:0] i_dc_addr = '0;
  logic        i_dc_stb = 1'b0;
  logic        i_dc_we = 1'b0;
  logic [31:0] i_dc_wdata = '0;
  logic [3:0]  i_dc_wsel = '0;
  logic        o_dc_ack;
  logic [31:0] o_dc_data;
  logic [14:0] o_mem_addr;
  logic        o_mem_stb;
  logic        o_mem_we;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_wsel;
  logic        i_mem_ack = 1'b0;
  logic [31:0] i_mem_data = '0;
  logic [1:0]  o_owner;
  logic        o_err;

  mem_arbiter #(
    .ADDR_WIDTH     (15),
    .MAX_OUTSTANDING(4)
  ) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_ic_addr  (i_ic_addr),
    .i_ic_stb   (i_ic_stb),
    .o_ic_ack   (o_ic_ack),
    .o_ic_data  (o_ic_data),
    .i_dc_addr  (i_dc_addr),
    .i_dc_stb   (i_dc_stb),
    .i_dc_we    (i_dc_we),
    .i_dc_wdata (i_dc_wdata),
    .i_dc_wsel  (i_dc_wsel),
    .o_dc_ack   (o_dc_ack),
    .o_dc_data  (o_dc_data),
    .o_mem_addr (o_mem_addr),
    .o_mem_stb  (o_mem_stb),
    .o_mem_we   (o_mem_we),
    .o_mem_wdata(o_mem_wdata),
    .o_mem_wsel (o_mem_wsel),
    .i_mem_ack  (i_mem_ack),
    .i_mem_data (i_mem_data),
    .o_owner    (o_owner),
    .o_err      (o_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [14:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wsel;
  } dc_beat_t;

  int n_checks = 0;
  int n_pass = 0;

  // Scoreboard: beats issued but not yet seen on the memory port, and memory's in-order queue.
  logic [14:0] ic_q[$];
  dc_beat_t    dc_q[$];
  int          mem_q[$];
  int          ic_unacked = 0;
  int          dc_unacked = 0;
  int          ack_src = 0;
  logic [31:0] ack_data = '0;
  int          n_iss = 0;
  int          n_fwd = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic reset_dut();
    @(negedge i_clk);
    i_rst_n    = 1'b0;
    i_ic_stb   = 1'b0;
    i_dc_stb   = 1'b0;
    i_dc_we    = 1'b0;
    i_mem_ack  = 1'b0;
    i_ic_addr  = '0;
    i_dc_addr  = '0;
    i_dc_wdata = '0;
    i_dc_wsel  = '0;
    i_mem_data = '0;
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_ctl"}, {o_mem_stb, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wsel,
                            o_owner, o_err, o_ic_ack, o_dc_ack}, 64'd0);
    check_eq({tag, "_data"}, {o_ic_data, o_dc_data}, 64'd0);
  endtask

  task automatic rand_step(input bit issue);
    dc_beat_t    b;
    logic [14:0] ia;
    int          new_src;
    @(negedge i_clk);
    new_src = 0;
    if (ack_src != 0) begin
      check_eq("r_ic_ack", o_ic_ack, ack_src == 1);
      check_eq("r_dc_ack", o_dc_ack, ack_src == 2);
      if (ack_src == 1) check_eq("r_ic_data", o_ic_data, ack_data);
      else check_eq("r_dc_data", o_dc_data, ack_data);
    end else if (o_ic_ack || o_dc_ack) begin
      check_eq("r_spurious_ack", {o_dc_ack, o_ic_ack}, 2'b00);
    end
    if (o_mem_stb) begin
      n_fwd++;
      if (o_owner == 2'b01 && ic_q.size() > 0) begin
        ia = ic_q.pop_front();
        check_eq("r_ic_addr", o_mem_addr, ia);
        check_eq("r_ic_wr_zero", {o_mem_we, o_mem_wdata, o_mem_wsel}, 64'd0);
        new_src = 1;
      end else if (o_owner == 2'b10 && dc_q.size() > 0) begin
        b = dc_q.pop_front();
        check_eq("r_dc_beat", {o_mem_addr, o_mem_we, o_mem_wdata, o_mem_wsel},
                 {b.addr, b.we, b.wdata, b.wsel});
        new_src = 2;
      end else begin
        check_eq("r_fwd_without_beat", o_mem_stb, 1'b0);
      end
    end
    // Memory only acks beats forwarded in earlier cycles, oldest first.
    if (mem_q.size() > 0 && $urandom_range(0, 1) == 1) begin
      ack_src    = mem_q.pop_front();
      ack_data   = $urandom;
      i_mem_ack  = 1'b1;
      i_mem_data = ack_data;
      if (ack_src == 1) ic_unacked--;
      else dc_unacked--;
    end else begin
      ack_src    = 0;
      i_mem_ack  = 1'b0;
      i_mem_data = $urandom;
    end
    if (new_src != 0) mem_q.push_back(new_src);
    // Requesters keep at most one beat unforwarded so the one-deep holder never overruns.
    if (issue && ic_q.size() == 0 && ic_unacked < 3 && $urandom_range(0, 2) != 0) begin
      ia        = 15'($urandom) & 15'h7ffc;
      i_ic_stb  = 1'b1;
      i_ic_addr = ia;
      ic_q.push_back(ia);
      ic_unacked++;
      n_iss++;
    end else begin
      i_ic_stb  = 1'b0;
      i_ic_addr = 15'($urandom);
    end
    if (issue && dc_q.size() == 0 && dc_unacked < 3 && $urandom_range(0, 2) != 0) begin
      b.addr     = 15'($urandom) & 15'h7ffc;
      b.we       = 1'($urandom);
      b.wdata    = $urandom;
      b.wsel     = 4'($urandom);
      i_dc_stb   = 1'b1;
      i_dc_addr  = b.addr;
      i_dc_we    = b.we;
      i_dc_wdata = b.wdata;
      i_dc_wsel  = b.wsel;
      dc_q.push_back(b);
      dc_unacked++;
      n_iss++;
    end else begin
      i_dc_stb   = 1'b0;
      i_dc_addr  = 15'($urandom);
      i_dc_we    = 1'($urandom);
      i_dc_wdata = $urandom;
      i_dc_wsel  = 4'($urandom);
    end
  endtask

  initial begin
    logic [1:0]  win, lose;
    logic [14:0] win_addr, lose_addr;
    bit          done;

    // IC-only burst of four beats, each acked two cycles after it reaches memory.
    reset_dut();
    check_quiet("reset");
    for (int k = 0; k < 12; k++) begin
      @(negedge i_clk);
      check_eq("a_owner", o_owner, (k >= 1 && k <= 7) ? 2'b01 : 2'b00);
      check_eq("a_stb", o_mem_stb, k >= 1 && k <= 4);
      check_eq("a_ic_ack", o_ic_ack, k >= 4 && k <= 7);
      if (k >= 1 && k <= 4) begin
        check_eq("a_addr", o_mem_addr, 15'h0100 + 15'(4 * (k - 1)));
        check_eq("a_we", o_mem_we, 1'b0);
      end
      if (k >= 4 && k <= 7) check_eq("a_ic_data", o_ic_data, 32'hA000_0000 + 32'(k - 1));
      i_ic_stb   = (k < 4);
      i_ic_addr  = 15'h0100 + 15'(4 * k);
      i_mem_ack  = (k >= 3 && k <= 6);
      i_mem_data = 32'hA000_0000 + 32'(k);
    end

    // Simultaneous requests in IDLE; the loser is held and served after release.
`ifdef ARB_ROUND_ROBIN_EN
    win = 2'b01; lose = 2'b10; win_addr = 15'h0200; lose_addr = 15'h0300;
`else
    win = 2'b10; lose = 2'b01; win_addr = 15'h0300; lose_addr = 15'h0200;
`endif
    reset_dut();
    for (int k = 0; k < 11; k++) begin
      @(negedge i_clk);
      check_eq("b_owner", o_owner, (k >= 1 && k <= 3) ? win : (k >= 5 && k <= 7) ? lose : 2'b00);
      check_eq("b_stb", o_mem_stb, k == 1 || k == 5);
      if (k == 1) check_eq("b_win_addr", o_mem_addr, win_addr);
      if (k == 5) check_eq("b_lose_addr", o_mem_addr, lose_addr);
      check_eq("b_acks", {o_dc_ack, o_ic_ack}, (k == 3) ? win : (k == 7) ? lose : 2'b00);
      i_ic_stb  = (k == 0);
      i_ic_addr = 15'h0200;
      i_dc_stb  = (k == 0);
      i_dc_addr = 15'h0300;
      i_dc_we   = 1'b0;
      i_mem_ack = (k == 2 || k == 6);
    end

    // DC write arriving mid IC burst waits for the IC release.
    reset_dut();
    for (int k = 0; k < 14; k++) begin
      @(negedge i_clk);
      check_eq("c_owner", o_owner, (k >= 1 && k <= 7) ? 2'b01 : (k >= 9 && k <= 11) ? 2'b10 : 2'b00);
      check_eq("c_stb", o_mem_stb, (k >= 1 && k <= 4) || k == 9);
      check_eq("c_ic_ack", o_ic_ack, k >= 4 && k <= 7);
      check_eq("c_dc_ack", o_dc_ack, k == 11);
      if (k >= 1 && k <= 4) check_eq("c_ic_we", o_mem_we, 1'b0);
      if (k == 9) begin
        check_eq("c_dc_beat", {o_mem_addr, o_mem_we, o_mem_wdata, o_mem_wsel},
                 {15'h0040, 1'b1, 32'hDEAD_BEEF, 4'b0011});
      end
      i_ic_stb   = (k < 4);
      i_ic_addr  = 15'h0100 + 15'(4 * k);
      i_dc_stb   = (k == 2);
      i_dc_addr  = 15'h0040;
      i_dc_we    = 1'b1;
      i_dc_wdata = 32'hDEAD_BEEF;
      i_dc_wsel  = 4'b0011;
      i_mem_ack  = (k >= 3 && k <= 6) || k == 10;
    end

    // Five unacked beats exceed four outstanding: sticky error until reset.
    reset_dut();
    for (int k = 0; k < 12; k++) begin
      @(negedge i_clk);
      check_eq("d_stb", o_mem_stb, k >= 1 && k <= 5);
      check_eq("d_err", o_err, k >= 6);
      i_ic_stb  = (k < 5);
      i_ic_addr = 15'h0100 + 15'(4 * k);
    end
    check_eq("d_owner_held", o_owner, 2'b01);
    reset_dut();
    check_eq("d_err_cleared", o_err, 1'b0);

    // Reset with beats in flight, then a stray ack.
    for (int k = 0; k < 2; k++) begin
      @(negedge i_clk);
      i_ic_stb  = 1'b1;
      i_ic_addr = 15'h0500 + 15'(4 * k);
    end
    @(negedge i_clk);
    check_eq("e_inflight", {o_owner, o_mem_stb}, {2'b01, 1'b1});
    i_ic_stb = 1'b0;
    i_rst_n  = 1'b0;
    #1;
    check_quiet("e_reset");
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    i_mem_ack  = 1'b1;
    i_mem_data = 32'h1234_5678;
    #1;
    check_eq("e_stray_acks", {o_dc_ack, o_ic_ack, o_ic_data, o_dc_data}, 64'd0);
    @(negedge i_clk);
    i_mem_ack = 1'b0;
    check_eq("e_stray_err", o_err, 1'b1);

    // Randomized traffic against the scoreboard, then drain.
    reset_dut();
    for (int i = 0; i < 3000; i++) rand_step(1'b1);
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      rand_step(1'b0);
      done = ic_q.size() == 0 && dc_q.size() == 0 && mem_q.size() == 0 && ack_src == 0 &&
             o_owner == 2'b00;
    end
    check_eq("r_drained", done, 1'b1);
    check_eq("r_fwd_count", n_fwd, n_iss);
    check_eq("r_err_end", o_err, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d checks passed so far",
             n_pass, n_checks);
    $fatal(1);
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 15, memory byte-address width.
REQ-002 Parameter MAX_OUTSTANDING, default 4, maximum beats in flight per grant.
REQ-003 i_clk  in  1  clock; i_rst_n  in  1  reset, asynchronous, active-low.
REQ-004 i_ic_addr  in  ADDR_WIDTH  instruction-refill beat address.
REQ-005 i_ic_stb  in  1  instruction-refill beat strobe, one beat per high cycle.
REQ-006 o_ic_ack  out  1  instruction beat acknowledge; o_ic_data  out  32  instruction beat data.
REQ-007 i_dc_addr  in  ADDR_WIDTH; i_dc_stb  in  1; i_dc_we  in  1; i_dc_wdata  in  32; i_dc_wsel  in  4  data-port beat request.
REQ-008 o_dc_ack  out  1; o_dc_data  out  32  data-port acknowledge and read data.
REQ-009 o_mem_addr  out  ADDR_WIDTH; o_mem_stb  out  1; o_mem_we  out  1; o_mem_wdata  out  32; o_mem_wsel  out  4  shared memory request.
REQ-010 i_mem_ack  in  1; i_mem_data  in  32  memory acknowledge and data, in order.
REQ-011 o_owner  out  2  current grant: 00 none, 01 IC, 10 DC; o_err  out  1  sticky protocol error.

Function
REQ-012 FSM states: IDLE, GNT_IC, GNT_DC.
REQ-013 IDLE: requester stb high -> grant that requester next cycle; beat is captured, not lost.
REQ-014 IDLE with both stb high: GNT_DC, unless overridden per REQ-025.
REQ-015 Captured IDLE beat and owner beats drive o_mem_* from registers: 1-cycle latency from requester stb to o_mem_stb.
REQ-016 o_mem_stb is high exactly one cycle per forwarded beat; o_mem_we/wdata/wsel are 0 during IC grant.
REQ-017 Non-owner stb held off: non-owner beats arriving during another grant are latched (one-deep) and issued once it is granted.
REQ-018 Outstanding counter, width clog2(MAX_OUTSTANDING)+1: +1 per forwarded beat, -1 per i_mem_ack, both same cycle -> unchanged.
REQ-019 o_ic_ack/o_dc_ack = i_mem_ack gated by owner, combinational; o_*_data = i_mem_data when owned, else 0.
REQ-020 Release to IDLE when owner stb low, no beat pending in the output register, counter == 0, and no i_mem_ack this cycle.
REQ-021 Forward with counter == MAX_OUTSTANDING, or i_mem_ack with counter == 0 -> o_err set; counter saturates and does not underflow.
REQ-022 o_err clears only on reset.

Reset
REQ-023 Asynchronous assert: state IDLE, counter 0, latches empty, all outputs 0, o_owner 00, o_err 0.
REQ-024 Reset mid-burst discards in-flight beats; acks arriving after release go to o_err per REQ-021.

Configuration
REQ-025 ARB_ROUND_ROBIN_EN defined: simultaneous requests in IDLE grant the requester not served last (initial last = DC, so IC first); undefined: fixed DC priority per REQ-014.

Structure
REQ-026 Shared package holds owner encoding (OWN_NONE/OWN_IC/OWN_DC), FSM state enum, default ADDR_WIDTH.
REQ-027 One sub-module, arb_req_latch, implements the one-deep per-requester beat holding register.

Verification
REQ-028 IC only: 4 stb beats at 0x0100..0x010C, ack 2 cycles later each -> o_mem_stb 1 cycle after each stb, 4 o_ic_ack, return to IDLE, o_owner 00.
REQ-029 Simultaneous IC and DC stb in IDLE -> o_owner 10 without macro, 01 with ARB_ROUND_ROBIN_EN; loser completes after release.
REQ-030 DC write 0xDEADBEEF, wsel 4'b0011, addr 0x0040 during IC burst -> issued only after IC release, o_mem_we 1, o_ic_ack never asserted for it.
REQ-031 Five beats without ack, MAX_OUTSTANDING 4 -> o_err 1 and stays 1 until reset.
REQ-032 Reset asserted with two beats outstanding -> all outputs 0 immediately; subsequent stray i_mem_ack -> o_err 1, no requester ack.
